// File: rtl/trace_mem_arbiter.sv
// Single-port trace-buffer memory shared by the trace logger (swap) and the host interface.
// Optional power-up clear sweep is enabled with the TRB_MEM_CLEAR_EN macro.
module trace_mem_arbiter #(
    parameter int unsigned TRB_WIDTH = 32,
    parameter int unsigned TRB_DEPTH = 64
) (
    input  logic                         CLK_I,
    input  logic                         RST_I,
    input  logic                         RW_I,
    input  logic [$clog2(TRB_DEPTH)-1:0] RW_PTR_I,
    input  logic [TRB_WIDTH-1:0]         DMEM_I,
    output logic [TRB_WIDTH-1:0]         DMEM_O,
    output logic                         RW_TURN_O,
    input  logic                         IF_REQ_I,
    input  logic                         IF_WE_I,
    input  logic [$clog2(TRB_DEPTH)-1:0] IF_PTR_I,
    input  logic [TRB_WIDTH-1:0]         IF_DATA_I,
    output logic [TRB_WIDTH-1:0]         IF_DATA_O,
    output logic                         IF_TURN_O,
    output logic                         BUSY_O
);

    localparam int unsigned AW = $clog2(TRB_DEPTH);

    localparam logic GRANT_LOG = 1'b0;
    localparam logic GRANT_IF  = 1'b1;

`ifdef TRB_MEM_CLEAR_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOG_RD, ST_LOG_XCH, ST_IF_RD, ST_IF_XCH, ST_CLEAR
    } state_e;
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOG_RD, ST_LOG_XCH, ST_IF_RD, ST_IF_XCH
    } state_e;
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [TRB_WIDTH-1:0] log_rdata_q, if_rdata_q;
    logic                 log_rd_en, if_rd_en;
    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;
    logic [TRB_WIDTH-1:0] mem_wdata;
    logic                 busy;

    logic [TRB_WIDTH-1:0] mem [TRB_DEPTH];

`ifdef TRB_MEM_CLEAR_EN
    logic [AW-1:0] clr_q, clr_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        log_rd_en    = 1'b0;
        if_rd_en     = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = addr_q;
        mem_wdata    = DMEM_I;
        RW_TURN_O    = 1'b0;
        IF_TURN_O    = 1'b0;
        busy         = 1'b0;
`ifdef TRB_MEM_CLEAR_EN
        clr_d        = clr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // On a tie the client not granted last time wins
                if (RW_I && (!IF_REQ_I || last_grant_q == GRANT_IF)) begin
                    state_d = ST_LOG_RD;
                end else if (IF_REQ_I) begin
                    state_d = ST_IF_RD;
                end
            end
            ST_LOG_RD: begin
                if (RW_I) begin
                    addr_d    = RW_PTR_I;
                    log_rd_en = 1'b1;
                    state_d   = ST_LOG_XCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOG_XCH: begin
                RW_TURN_O    = 1'b1;
                mem_we       = 1'b1;
                mem_wdata    = DMEM_I;
                last_grant_d = GRANT_LOG;
                state_d      = ST_IDLE;
            end
            ST_IF_RD: begin
                if (IF_REQ_I) begin
                    addr_d   = IF_PTR_I;
                    if_rd_en = 1'b1;
                    state_d  = ST_IF_XCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IF_XCH: begin
                IF_TURN_O    = 1'b1;
                mem_we       = IF_WE_I;
                mem_wdata    = IF_DATA_I;
                last_grant_d = GRANT_IF;
                state_d      = ST_IDLE;
            end
`ifdef TRB_MEM_CLEAR_EN
            ST_CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_q;
                mem_wdata = '0;
                clr_d     = clr_q + 1'b1;
                if (clr_q == AW'(TRB_DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // Reset held: the clear state must not write and a pending swap is dropped
        if (RST_I) begin
            mem_we = 1'b0;
        end
    end

    assign BUSY_O    = busy;
    assign DMEM_O    = log_rdata_q;
    assign IF_DATA_O = if_rdata_q;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q      <= RESET_STATE;
            last_grant_q <= GRANT_IF;
            addr_q       <= '0;
            log_rdata_q  <= '0;
            if_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            if (log_rd_en) begin
                log_rdata_q <= mem[RW_PTR_I];
            end
            if (if_rd_en) begin
                if_rdata_q <= mem[IF_PTR_I];
            end
        end
    end

`ifdef TRB_MEM_CLEAR_EN
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            clr_q <= '0;
        end else begin
            clr_q <= clr_d;
        end
    end
`endif

    // Storage is deliberately not reset
    always_ff @(posedge CLK_I) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_trace_mem_arbiter.sv
// Randomized self-checking bench for trace_mem_arbiter against a transaction-level model.
// Covers tie-break ordering, turn latency, abort, wrap, and reset during an exchange.
module tb_trace_mem_arbiter;

    localparam int W = 32;
    localparam int D = 64;

    logic          CLK_I, RST_I;
    logic          RW_I, IF_REQ_I, IF_WE_I;
    logic [5:0]    RW_PTR_I, IF_PTR_I;
    logic [W-1:0]  DMEM_I, DMEM_O, IF_DATA_I, IF_DATA_O;
    logic          RW_TURN_O, IF_TURN_O, BUSY_O;

    trace_mem_arbiter #(.TRB_WIDTH(W), .TRB_DEPTH(D)) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .RW_I      (RW_I),
        .RW_PTR_I  (RW_PTR_I),
        .DMEM_I    (DMEM_I),
        .DMEM_O    (DMEM_O),
        .RW_TURN_O (RW_TURN_O),
        .IF_REQ_I  (IF_REQ_I),
        .IF_WE_I   (IF_WE_I),
        .IF_PTR_I  (IF_PTR_I),
        .IF_DATA_I (IF_DATA_I),
        .IF_DATA_O (IF_DATA_O),
        .IF_TURN_O (IF_TURN_O),
        .BUSY_O    (BUSY_O)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: memory contents with a known flag, arbitration history, output holds
    logic [W-1:0] mdl_mem [D];
    bit           mdl_known [D];
    bit           mdl_last_if;
    logic [W-1:0] mdl_dmem, mdl_ifdata;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_last_if = 1'b1;
        mdl_dmem    = '0;
        mdl_ifdata  = '0;
    endtask

    // One arbitration round; the turn cycle counts edges after inputs are applied
    task automatic round(input bit lreq, input logic [5:0] lptr, input logic [W-1:0] ldata,
                         input bit ireq, input bit iwe, input logic [5:0] iptr,
                         input logic [W-1:0] idata);
        int exp_l, exp_i;
        bit got_l, got_i;
        exp_l = -1;
        exp_i = -1;
        got_l = 0;
        got_i = 0;
        if (lreq && ireq) begin
            if (mdl_last_if) begin exp_l = 2; exp_i = 5; end
            else begin exp_i = 2; exp_l = 5; end
        end else if (lreq) begin
            exp_l = 2;
        end else if (ireq) begin
            exp_i = 2;
        end
        RW_I = lreq; RW_PTR_I = lptr; DMEM_I = ldata;
        IF_REQ_I = ireq; IF_WE_I = iwe; IF_PTR_I = iptr; IF_DATA_I = idata;
        for (int c = 1; c <= 8; c++) begin
            @(posedge CLK_I);
            #1;
            if (RW_TURN_O) begin
                check_eq("log_turn_cycle", c, exp_l);
                if (got_l) check_eq("log_turn_once", 1, 0);
                if (mdl_known[lptr]) check_eq("log_old_word", DMEM_O, mdl_mem[lptr]);
                mdl_dmem        = mdl_mem[lptr];
                mdl_mem[lptr]   = ldata;
                mdl_known[lptr] = 1'b1;
                mdl_last_if     = 1'b0;
                got_l = 1;
                RW_I  = 1'b0;
            end
            if (IF_TURN_O) begin
                check_eq("if_turn_cycle", c, exp_i);
                if (got_i) check_eq("if_turn_once", 1, 0);
                if (mdl_known[iptr]) check_eq("if_old_word", IF_DATA_O, mdl_mem[iptr]);
                mdl_ifdata = mdl_mem[iptr];
                if (iwe) begin
                    mdl_mem[iptr]   = idata;
                    mdl_known[iptr] = 1'b1;
                end
                mdl_last_if = 1'b1;
                got_i = 1;
                IF_REQ_I = 1'b0;
            end
        end
        check_eq("log_served", got_l, lreq);
        check_eq("if_served", got_i, ireq);
        if (!$isunknown(mdl_dmem)) check_eq("dmem_hold", DMEM_O, mdl_dmem);
        if (!$isunknown(mdl_ifdata)) check_eq("ifdata_hold", IF_DATA_O, mdl_ifdata);
    endtask

    task automatic wait_clear();
`ifdef TRB_MEM_CLEAR_EN
        int n;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK_I);
            #1;
            n++;
            if (!BUSY_O) break;
        end
        check_eq("busy_cycles", n, D);
        for (int i = 0; i < D; i++) begin
            mdl_mem[i]   = '0;
            mdl_known[i] = 1'b1;
        end
`endif
    endtask

    task automatic abort_test(input logic [5:0] p);
        RW_I = 1'b1; RW_PTR_I = p; DMEM_I = 32'hDEAD_BEEF;
        @(posedge CLK_I);
        #1;
        RW_I = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK_I);
            #1;
            check_eq("abort_no_turn", RW_TURN_O, 0);
        end
        check_eq("abort_dmem_hold", DMEM_O, mdl_dmem);
        round(0, 0, 0, 1, 0, p, 0);
    endtask

    task automatic reset_mid_access(input logic [5:0] p);
        RW_I = 1'b1; RW_PTR_I = p; DMEM_I = 32'h1357_9BDF;
        @(posedge CLK_I);
        @(posedge CLK_I);
        #1;
        check_eq("pre_reset_turn", RW_TURN_O, 1);
        RST_I = 1'b1;
        #1;
        check_eq("rst_turn_drop", RW_TURN_O, 0);
        check_eq("rst_dmem_zero", DMEM_O, 0);
        check_eq("rst_ifdata_zero", IF_DATA_O, 0);
        RW_I = 1'b0;
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        model_reset();
        wait_clear();
        round(0, 0, 0, 1, 0, p, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] a, b;
        int mode;
        RST_I = 1'b1;
        RW_I = 0; RW_PTR_I = 0; DMEM_I = 0;
        IF_REQ_I = 0; IF_WE_I = 0; IF_PTR_I = 0; IF_DATA_I = 0;
        for (int i = 0; i < D; i++) mdl_known[i] = 1'b0;
        model_reset();
        #3;
        check_eq("reset_rw_turn", RW_TURN_O, 0);
        check_eq("reset_if_turn", IF_TURN_O, 0);
        check_eq("reset_dmem", DMEM_O, 0);
        check_eq("reset_ifdata", IF_DATA_O, 0);
`ifdef TRB_MEM_CLEAR_EN
        check_eq("reset_busy", BUSY_O, 1);
`else
        check_eq("reset_busy", BUSY_O, 0);
`endif
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        wait_clear();

        // Tie from reset: logger first, interface then reads the logger's word
        round(1, 3, 32'hCAFE_0003, 1, 0, 3, 0);
        round(1, 5, 32'hA5A5_A5A5, 0, 0, 0, 0);
        round(1, 5, 32'h0000_0001, 0, 0, 0, 0);
        round(0, 0, 0, 1, 0, 5, 0);
        round(0, 0, 0, 1, 0, 5, 0);
        abort_test(5);
        round(1, 62, 32'h6262_6262, 0, 0, 0, 0);
        round(1, 63, 32'h6363_6363, 0, 0, 0, 0);
        round(1, 0, 32'h0000_0C00, 0, 0, 0, 0);
        round(1, 63, 32'h7777_7777, 0, 0, 0, 0);
        round(1, 0, 32'h0000_0D00, 0, 0, 0, 0);

        for (int i = 0; i < D; i++) round(0, 0, 0, 1, 1, 6'(i), $urandom);

        reset_mid_access(6'd9);

        for (int r = 0; r < 250; r++) begin
            mode = $urandom_range(0, 2);
            a = 6'($urandom);
            b = ($urandom_range(0, 9) < 3) ? a : 6'($urandom);
            round(mode != 1, a, $urandom, mode != 0, $urandom_range(0, 1) == 1, b, $urandom);
        end
        abort_test(6'($urandom));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/trace_mem_arbiter.md
# trace_mem_arbiter

Single-port trace-buffer memory with a two-client arbiter; it is the responder side of the trace-logger RW handshake. It owns a TRB_DEPTH x TRB_WIDTH word array and grants word-exchange turns to two clients. The logger client swaps a word: it writes its trace word and receives the old content. The host-interface client reads, or optionally writes, one word per turn. It sits between the trace logger and the debug-interface readout path.

## Interface
- TRB_WIDTH, 32: word width in bits.
- TRB_DEPTH, 64: number of words; power of two, minimum 2.
- CLK_I  in  1  single clock; all logic on its rising edge.
- RST_I  in  1  asynchronous, active-high reset.
- RW_I  in  1  logger request; held high until the turn.
- RW_PTR_I  in  $clog2(TRB_DEPTH)  logger address; stable while RW_I is high.
- DMEM_I  in  TRB_WIDTH  logger word to write.
- DMEM_O  out  TRB_WIDTH  old word at RW_PTR_I; valid in the RW_TURN_O cycle.
- RW_TURN_O  out  1  one-cycle logger grant pulse.
- IF_REQ_I  in  1  interface request; held high until the turn.
- IF_WE_I  in  1  interface write enable; 0 means read-only.
- IF_PTR_I  in  $clog2(TRB_DEPTH)  interface address.
- IF_DATA_I  in  TRB_WIDTH  interface write word.
- IF_DATA_O  out  TRB_WIDTH  old word at IF_PTR_I; valid in the IF_TURN_O cycle.
- IF_TURN_O  out  1  one-cycle interface grant pulse.
- BUSY_O  out  1  high while a clear sweep runs; requests are not served.

## Operation
- States: ST_IDLE, ST_LOG_RD, ST_LOG_XCH, ST_IF_RD, ST_IF_XCH, and ST_CLEAR (macro only).
- ST_IDLE, logger request only: go to ST_LOG_RD.
- ST_IDLE, interface request only: go to ST_IF_RD.
- ST_IDLE, both requests: grant the client not granted last. The last_grant flag resets to "interface", so the logger wins the first tie.
- ST_LOG_RD: latch RW_PTR_I into the address register and register mem[addr] into the read register; go to ST_LOG_XCH.
- ST_LOG_RD abort: if RW_I is low in this cycle, return to ST_IDLE with no access and no grant.
- ST_LOG_XCH: RW_TURN_O=1 and DMEM_O = read register; mem[addr] <= DMEM_I at the closing edge; last_grant <= logger; go to ST_IDLE.
- ST_IF_RD and ST_IF_XCH: same as the logger path, using IF_PTR_I, IF_DATA_O and IF_TURN_O. The write happens only if IF_WE_I=1 during ST_IF_XCH.
- Addresses are taken modulo TRB_DEPTH; no bound check is needed.
- Only one access is in flight at a time. Same-address requests from both clients are serialized; the second client sees the first client's write.
- DMEM_O and IF_DATA_O hold their last value outside turn cycles.

## Timing
- Reset: all outputs are 0 and state is ST_IDLE; with the macro, state is ST_CLEAR and BUSY_O=1.
- Memory contents are not reset.
- Latency: a request sampled high in ST_IDLE at edge t gives a turn pulse in cycle t+2.
- An access occupies 3 cycles including the return to ST_IDLE. The maximum service rate is one turn per 3 cycles.
- When both clients hold requests, turns alternate: logger, interface, logger, and so on.
- A requester must drop its request in the cycle after its turn. If it is still high in ST_IDLE, that is a new request.
- Reset asserted mid-access: the pending write is discarded, no turn pulse is issued, and outputs return to 0 asynchronously.

## Configuration
- TRB_MEM_CLEAR_EN defined: after reset release, ST_CLEAR writes 0 to addresses 0..TRB_DEPTH-1, one per cycle.
  - BUSY_O is high for exactly TRB_DEPTH cycles, then the block enters ST_IDLE.
  - Requests made during the sweep wait and are served afterwards.
- TRB_MEM_CLEAR_EN undefined: no ST_CLEAR state, BUSY_O is tied to 0, and memory powers up undefined.

## Test plan
- Logger swap after clear: hold RW_I=1, RW_PTR_I=5, DMEM_I=0xA5A5A5A5 → RW_TURN_O pulses 2 cycles later with DMEM_O=0 (macro on). A second swap at address 5 with 0x1 returns 0xA5A5A5A5.
- Interface read-only: IF_WE_I=0, IF_PTR_I=5 → IF_DATA_O=0x1 at IF_TURN_O. A follow-up read of address 5 still returns 0x1.
- Simultaneous requests from reset, both at address 3: logger is granted first. Interface turn follows 3 cycles after the logger turn and returns the logger's written word.
- Abort: RW_I high for one cycle only → no RW_TURN_O, and mem[RW_PTR_I] is unchanged on readback.
- Wrap: logger swaps at addresses 62, 63, then 0 (TRB_DEPTH=64) → each returns the prior content of that address, and address 0 is not aliased to 63.
- Reset mid-access: assert RST_I during ST_LOG_XCH → RW_TURN_O drops immediately, the location keeps its old value, and BUSY_O=1 for 64 cycles after release (macro on).
